trng_wb_harvester: RTL and testbench

//  Wishbone initiator that drives the TRNG wishbone responder: programs ring-osc trims, then

---
 rtl/trng_wb_harvester.sv | 216 +++++++++++++++++++++
 tb/tb_trng_wb_harvester.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_wb_harvester.sv
// ---------------------------------------------------------------------------
// trng_wb_harvester
//
// Wishbone initiator for the TRNG responder. After enable it writes the
// fast and slow ring-oscillator trim codes (carried in the address, one
// cycle each, no ack expected), then repeatedly issues single 32-bit read
// cycles. Each acked word is pushed into a small show-ahead FIFO for a
// downstream consumer. Only one bus cycle is ever outstanding, and a read
// that sees no ack within TIMEOUT cycles is abandoned and flagged.
//
// Handshake (rnd_*): rnd_valid_o is high whenever the FIFO holds a word and
// rnd_data_o is then the oldest word; the word is consumed on a clock edge
// where rnd_valid_o & rnd_ready_i are both high. rnd_ready_i with an empty
// FIFO has no effect. rnd_data_o reads 0 while rnd_valid_o is low.
//
// Ports
//   wb_clk_i      clock
//   rst_ni        asynchronous active-low reset
//   enable_i      level: harvest while high
//   retrim_i      pulse: rerun the trim writes before the next read
//   wbm_cyc_o     wishbone cycle
//   wbm_stb_o     wishbone strobe
//   wbm_we_o      1 = trim write, 0 = read
//   wbm_adr_o     trim: {3'b000, sel, code} (sel 1 = fast, 0 = slow); read: 0
//   wbm_dat_o     always 0
//   wbm_dat_i     read data, taken when wbm_ack_i is high in a read
//   wbm_ack_i     responder ack
//   rnd_data_o    FIFO head word
//   rnd_valid_o   FIFO non-empty
//   rnd_ready_i   consumer pops the head word
//   fifo_level_o  words currently stored
//   timeout_o     sticky read-timeout flag, cleared while enable_i is low
//   busy_o        FSM is not idle
// ---------------------------------------------------------------------------
module trng_wb_harvester #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int TRIM_FAST  = 13,
  parameter int TRIM_SLOW  = 13
) (
  input  logic                            wb_clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic                            retrim_i,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [8:0]                      wbm_adr_o,
  output logic [31:0]                     wbm_dat_o,
  input  logic [31:0]                     wbm_dat_i,
  input  logic                            wbm_ack_i,
  output logic [31:0]                     rnd_data_o,
  output logic                            rnd_valid_o,
  input  logic                            rnd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            timeout_o,
  output logic                            busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [4:0]    TRIM_FAST_C = 5'(TRIM_FAST);
  localparam logic [4:0]    TRIM_SLOW_C = 5'(TRIM_SLOW);
  localparam logic [8:0]    ADR_FAST    = {3'b000, 1'b1, TRIM_FAST_C};
  localparam logic [8:0]    ADR_SLOW    = {3'b000, 1'b0, TRIM_SLOW_C};
  localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_FAST = 3'd1,
    WR_SLOW = 3'd2,
    RD_REQ  = 3'd3,
    RD_GAP  = 3'd4
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            trim_done_q;
  logic            retrim_pend_q;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;

  logic            push;
  logic            pop;

  // An ack only counts while a read is actually on the bus.
  assign push = (state_q == RD_REQ) && wbm_ack_i;
  assign pop  = (level_q != '0) && rnd_ready_i;

  assign wbm_dat_o    = '0;
  assign rnd_valid_o  = (level_q != '0);
  assign rnd_data_o   = rnd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o = level_q;
  assign busy_o       = (state_q != IDLE);

  // -------------------------------------------------------------------------
  // Bus FSM. Bus outputs are registered and change together with the state,
  // so each state's bus values are visible for exactly the cycles spent in it.
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wbm_cyc_o     <= 1'b0;
      wbm_stb_o     <= 1'b0;
      wbm_we_o      <= 1'b0;
      wbm_adr_o     <= '0;
      wait_cnt_q    <= '0;
      trim_done_q   <= 1'b0;
      retrim_pend_q <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && (!trim_done_q || retrim_pend_q)) begin
            state_q   <= WR_FAST;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= ADR_FAST;
          end else if (enable_i && (level_q < LEVEL_FULL)) begin
            // Free slot guaranteed: with one read in flight the push fits.
            state_q    <= RD_REQ;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wait_cnt_q <= '0;
          end
        end
        WR_FAST: begin
          state_q   <= WR_SLOW;
          wbm_adr_o <= ADR_SLOW;
        end
        WR_SLOW: begin
          state_q       <= RD_GAP;
          trim_done_q   <= 1'b1;
          retrim_pend_q <= 1'b0;
          wbm_cyc_o     <= 1'b0;
          wbm_stb_o     <= 1'b0;
          wbm_we_o      <= 1'b0;
          wbm_adr_o     <= '0;
        end
        RD_REQ: begin
          // Ack wins over a timeout landing on the same cycle.
          if (wbm_ack_i) begin
            state_q   <= RD_GAP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        RD_GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          wbm_adr_o <= '0;
        end
      endcase

      // A retrim request arriving while WR_SLOW retires still forces another
      // trim pass, so the set overrides the clear above.
      if (retrim_i) begin
        retrim_pend_q <= 1'b1;
      end
      if (!enable_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage: data array needs no reset, emptiness is tracked by level.
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wbm_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_wb_harvester.sv
// ---------------------------------------------------------------------------
// tb_trng_wb_harvester
//
// Directed bench for trng_wb_harvester. A behavioural wishbone responder
// acks reads after a programmable delay with known words; each word it
// returns is queued as the expected consumer output, and a monitor compares
// every word the DUT hands over against that queue in order.
// Inputs change at negedge+1, the monitor looks at negedge+3, direct checks
// are made at posedge+1 or negedge+1.
// ---------------------------------------------------------------------------
module tb_trng_wb_harvester;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        enable;
  logic        retrim;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [8:0]  adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [2:0]  lvl;
  logic        timeout;
  logic        busy;

  trng_wb_harvester #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT),
    .TRIM_FAST (13),
    .TRIM_SLOW (13)
  ) dut (
    .wb_clk_i    (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .retrim_i    (retrim),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .rnd_data_o  (rnd_data),
    .rnd_valid_o (rnd_valid),
    .rnd_ready_i (rnd_ready),
    .fifo_level_o(lvl),
    .timeout_o   (timeout),
    .busy_o      (busy)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {16'hA5A5, 16'(i + 1)};
  endfunction

  // ---------------- responder + bus observers ----------------
  bit ack_en    = 1'b1;
  int ack_delay = 3;
  int rcnt      = 0;
  int widx      = 0;
  int acks      = 0;
  int wr_cnt    = 0;
  int rd_starts = 0;
  bit prev_rd   = 1'b0;
  bit seen_rd   = 1'b0;
  int gap_run   = 0;
  int gap_min   = 1000;
  int lvl_max   = 0;

  always @(negedge clk) begin
    bit rd_now;
    if (!rst_n) begin
      ack     = 1'b0;
      dat_i   = '0;
      rcnt    = 0;
      prev_rd = 1'b0;
    end else begin
      rd_now = cyc && stb && !we;
      if (cyc && stb && we) wr_cnt++;
      if (rd_now && !prev_rd) begin
        rd_starts++;
        if (seen_rd && gap_run < gap_min) gap_min = gap_run;
        seen_rd = 1'b1;
      end
      if (!cyc) gap_run++;
      else gap_run = 0;
      prev_rd = rd_now;
      if (int'(lvl) > lvl_max) lvl_max = int'(lvl);
      if (rd_now && !ack) begin
        rcnt++;
        if (ack_en && rcnt >= ack_delay) begin
          ack   = 1'b1;
          dat_i = word_of(widx);
          exp_q.push_back(word_of(widx));
          widx++;
          acks++;
          rcnt  = 0;
        end
      end else begin
        ack   = 1'b0;
        dat_i = '0;
        rcnt  = 0;
      end
    end
  end

  // ---------------- monitor: compare every handed-over word ----------------
  always @(negedge clk) begin
    #3;
    if (rst_n && rnd_valid && rnd_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", rnd_data, 32'h0);
        check("sb_queue_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_data", rnd_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic pstep();
    @(posedge clk);
    #1;
  endtask

  task automatic nsteps(input int n);
    for (int i = 0; i < n; i++) nstep();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    int wr0;
    int rd0;
    int a0;
    bit wr_seen;

    rst_n     = 1'b0;
    enable    = 1'b0;
    retrim    = 1'b0;
    rnd_ready = 1'b0;
    nsteps(3);

    // reset state
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_data", rnd_data, 32'd0);
    check("rst_level", 32'(lvl), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    nstep();

    // 1: trim writes then first read, ack after 3 cycles
    wr_cnt    = 0;
    rd_starts = 0;
    enable    = 1'b1;
    pstep();
    check("t1_fast_cyc", 32'(cyc & stb & we), 32'd1);
    check("t1_fast_adr", 32'(adr), 32'h02D);
    check("t1_busy", 32'(busy), 32'd1);
    pstep();
    check("t1_slow_we", 32'(cyc & stb & we), 32'd1);
    check("t1_slow_adr", 32'(adr), 32'h00D);
    pstep();
    check("t1_gap_cyc", 32'(cyc), 32'd0);
    pstep();
    check("t1_idle_cyc", 32'(cyc), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    pstep();
    check("t1_rd_req", 32'(cyc & stb & !we), 32'd1);
    check("t1_rd_adr", 32'(adr), 32'h000);
    pstep();
    pstep();
    check("t1_valid_before_ack", 32'(rnd_valid), 32'd0);
    pstep();
    check("t1_valid", 32'(rnd_valid), 32'd1);
    check("t1_data", rnd_data, 32'hA5A5_0001);
    check("t1_level", 32'(lvl), 32'd1);
    check("t1_writes", 32'(wr_cnt), 32'd2);

    // 2: consumer stalled, FIFO fills, then one pop gives one read
    n = 0;
    while (!(lvl == 3'(FIFO_DEPTH) && !busy) && n < 300) begin
      nstep();
      n++;
    end
    check("t2_fill_in_time", 32'(n < 300), 32'd1);
    nsteps(20);
    check("t2_reads_when_full", 32'(rd_starts), 32'(FIFO_DEPTH));
    check("t2_cyc_idle", 32'(cyc), 32'd0);
    check("t2_level_full", 32'(lvl), 32'(FIFO_DEPTH));
    rnd_ready = 1'b1;
    nstep();
    rnd_ready = 1'b0;
    nsteps(30);
    check("t2_reads_after_pop", 32'(rd_starts), 32'(FIFO_DEPTH + 1));
    check("t2_level_refill", 32'(lvl), 32'(FIFO_DEPTH));
    enable    = 1'b0;
    rnd_ready = 1'b1;
    nsteps(10);
    rnd_ready = 1'b0;
    check("t2_drained", 32'(lvl), 32'd0);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: responder silent -> timeout after TIMEOUT cycles
    ack_en = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!cyc && n < 20) begin
      nstep();
      n++;
    end
    check("t3_read_started", 32'(cyc & !we), 32'd1);
    cnt = 0;
    while (cyc && cnt < 200) begin
      cnt++;
      nstep();
    end
    check("t3_wait_cycles", 32'(cnt), 32'(TIMEOUT));
    check("t3_timeout_set", 32'(timeout), 32'd1);
    check("t3_cyc_dropped", 32'(cyc | stb), 32'd0);
    enable = 1'b0;
    nsteps(3);
    check("t3_timeout_cleared", 32'(timeout), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    ack_en = 1'b1;
    enable = 1'b1;
    n = 0;
    while (lvl == 0 && n < 50) begin
      nstep();
      n++;
    end
    check("t3_retry_word", 32'(lvl != 0), 32'd1);
    check("t3_no_timeout", 32'(timeout), 32'd0);
    enable    = 1'b0;
    rnd_ready = 1'b1;
    nsteps(15);
    rnd_ready = 1'b0;
    check("t3_drained", 32'(lvl), 32'd0);

    // 4: consumer always ready -> streaming, level stays <= 1
    ack_delay = 1;
    rnd_ready = 1'b1;
    gap_min   = 1000;
    seen_rd   = 1'b0;
    lvl_max   = 0;
    rd0       = rd_starts;
    enable    = 1'b1;
    n = 0;
    while (rd_starts < rd0 + 8 && n < 400) begin
      nstep();
      n++;
    end
    check("t4_reads_in_time", 32'(n < 400), 32'd1);
    enable = 1'b0;
    nsteps(20);
    check("t4_level_max", 32'(lvl_max <= 1), 32'd1);
    check("t4_gap_seen", 32'(gap_min < 1000), 32'd1);
    check("t4_gap_min", 32'(gap_min >= 1), 32'd1);
    check("t4_level_end", 32'(lvl), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: retrim pulse during a read -> read finishes, then both trim writes
    ack_delay = 5;
    enable    = 1'b1;
    n = 0;
    while (!(cyc && stb && !we) && n < 20) begin
      nstep();
      n++;
    end
    check("t5_in_read", 32'(cyc & stb & !we), 32'd1);
    wr0     = wr_cnt;
    rd0     = rd_starts;
    a0      = acks;
    wr_seen = 1'b0;
    retrim  = 1'b1;
    nstep();
    retrim = 1'b0;
    n = 0;
    while (rd_starts <= rd0 && n < 200) begin
      if (wr_cnt != wr0 && !wr_seen) begin
        wr_seen = 1'b1;
        check("t5_write_after_ack", 32'(acks > a0), 32'd1);
      end
      nstep();
      n++;
    end
    check("t5_trim_seen", 32'(wr_seen), 32'd1);
    check("t5_two_writes", 32'(wr_cnt - wr0), 32'd2);
    check("t5_no_timeout", 32'(timeout), 32'd0);
    enable = 1'b0;
    nsteps(20);
    check("t5_level_end", 32'(lvl), 32'd0);

    // 6: async reset in the middle of a read
    rnd_ready = 1'b0;
    ack_delay = 2;
    enable    = 1'b1;
    n = 0;
    while (lvl < 2 && n < 100) begin
      nstep();
      n++;
    end
    check("t6_prefill", 32'(lvl >= 2), 32'd1);
    ack_en = 1'b0;
    n = 0;
    while (!(cyc && !we) && n < 20) begin
      nstep();
      n++;
    end
    check("t6_in_read", 32'(cyc & !we), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_cyc", 32'(cyc | stb), 32'd0);
    check("t6_adr", 32'(adr), 32'd0);
    check("t6_valid", 32'(rnd_valid), 32'd0);
    check("t6_data", rnd_data, 32'd0);
    check("t6_level", 32'(lvl), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    nsteps(2);
    ack_en = 1'b1;
    wr0    = wr_cnt;
    rd0    = rd_starts;
    rst_n  = 1'b1;
    n = 0;
    while (rd_starts <= rd0 && n < 50) begin
      nstep();
      n++;
    end
    check("t6_retrim_writes", 32'(wr_cnt - wr0), 32'd2);
    enable = 1'b0;
    nsteps(10);
    rnd_ready = 1'b1;
    nsteps(10);
    check("t6_drained", 32'(lvl), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
